// File: rtl/vend_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vend_pkg
// Purpose  : Shared types and constants for the vending sequencer: the
//            controller state encoding, coin values, default product prices,
//            the credit ceiling and one-hot test helpers.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package vend_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CREDIT   = 2'd1,
        ST_DISPENSE = 2'd2,
        ST_CHANGE   = 2'd3
    } state_e;

    // Coin values, indexed by the coin bit position on D / VF.
    localparam logic [3:0] C_COIN_1   = 4'd1;
    localparam logic [3:0] C_COIN_2   = 4'd2;
    localparam logic [3:0] C_COIN_5   = 4'd5;

    localparam int         DEF_PRICE0 = 3;
    localparam int         DEF_PRICE1 = 5;
    localparam int         DEF_PRICE2 = 7;
    localparam int         DEF_PRICE3 = 10;

    localparam logic [4:0] MAX_CREDIT = 5'd15;

    function automatic logic is_onehot3(input logic [2:0] v);
        return (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
    endfunction

    function automatic logic is_onehot4(input logic [3:0] v);
        return (v == 4'b0001) || (v == 4'b0010) ||
               (v == 4'b0100) || (v == 4'b1000);
    endfunction

endpackage
`default_nettype wire

// File: rtl/vend_change_gen.sv
`default_nettype none
// ============================================================================
// Module   : vend_change_gen
// Purpose  : Greedy change selector. Picks the largest coin not exceeding
//            the current credit and reports the credit left after paying it.
// Ports    : credit_i [3:0] - credit still owed to the customer
//            coin_o   [2:0] - one-hot coin to return (100=5, 010=2, 001=1),
//                             all zero when credit_i is zero
//            remain_o [3:0] - credit_i minus the selected coin value
// Revision : 1.0 - initial release
// ============================================================================
module vend_change_gen
    import vend_pkg::*;
(
    input  logic [3:0] credit_i,
    output logic [2:0] coin_o,
    output logic [3:0] remain_o
);

    always_comb begin
        coin_o   = 3'b000;
        remain_o = credit_i;
        if (credit_i >= C_COIN_5) begin
            coin_o   = 3'b100;
            remain_o = credit_i - C_COIN_5;
        end else if (credit_i >= C_COIN_2) begin
            coin_o   = 3'b010;
            remain_o = credit_i - C_COIN_2;
        end else if (credit_i >= C_COIN_1) begin
            coin_o   = 3'b001;
            remain_o = credit_i - C_COIN_1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/vend_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : vend_sequencer
// Purpose  : Vending machine controller. Accumulates coin credit, dispenses
//            a selected product when credit allows, then returns change one
//            coin per cycle using a greedy 5/2/1 selection.
// Ports    : clock        - rising-edge clock
//            reset        - synchronous active-high reset
//            P      [3:0] - product select, one-hot, level-sampled
//            D      [2:0] - coin inserted, one-hot pulse (1, 2, 5 units)
//            cancel       - request refund of the current credit
//            OUT    [3:0] - one-hot dispense strobe (registered)
//            VF     [2:0] - one-hot coin-return pulse (registered)
//            credit [3:0] - current credit, 0..15
//            deny         - one-cycle pulse on an unaffordable selection
//            busy         - high while dispensing or returning change
// Revision : 1.0 - initial release
// ============================================================================
module vend_sequencer
    import vend_pkg::*;
#(
    parameter int PRICE0      = DEF_PRICE0,
    parameter int PRICE1      = DEF_PRICE1,
    parameter int PRICE2      = DEF_PRICE2,
    parameter int PRICE3      = DEF_PRICE3,
    parameter int DISP_CYCLES = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] P,
    input  logic [2:0] D,
    input  logic       cancel,
    output logic [3:0] OUT,
    output logic [2:0] VF,
    output logic [3:0] credit,
    output logic       deny,
    output logic       busy
);

    localparam int                 C_CNT_W  = $clog2(DISP_CYCLES + 1);
    localparam logic [C_CNT_W-1:0] C_CNT_LD = C_CNT_W'(DISP_CYCLES - 1);
    localparam logic [C_CNT_W-1:0] C_CNT_1  = C_CNT_W'(1);
    localparam logic [4:0]         C_PRICE0 = 5'(PRICE0);
    localparam logic [4:0]         C_PRICE1 = 5'(PRICE1);
    localparam logic [4:0]         C_PRICE2 = 5'(PRICE2);
    localparam logic [4:0]         C_PRICE3 = 5'(PRICE3);

    state_e             state_q;
    logic [3:0]         credit_q;
    logic [3:0]         out_q;
    logic [2:0]         vf_q;
    logic               deny_q;
    logic [C_CNT_W-1:0] cnt_q;

    logic [4:0]         w_coin_val;
    logic               w_coin_valid;
    logic [4:0]         w_sum;
    logic               w_coin_fits;
    logic               w_sel_valid;
    logic [4:0]         w_price;
    logic               w_afford;
    logic [2:0]         w_chg_coin;
    logic [3:0]         w_chg_remain;

    // Coin decode; sum is one bit wider so an overflowing coin is detectable.
    always_comb begin
        w_coin_val = 5'd0;
        case (D)
            3'b001:  w_coin_val = {1'b0, C_COIN_1};
            3'b010:  w_coin_val = {1'b0, C_COIN_2};
            3'b100:  w_coin_val = {1'b0, C_COIN_5};
            default: w_coin_val = 5'd0;
        endcase
    end

    assign w_coin_valid = is_onehot3(D);
    assign w_sum        = {1'b0, credit_q} + w_coin_val;
    assign w_coin_fits  = (w_sum <= MAX_CREDIT);

    always_comb begin
        w_price = 5'd0;
        case (P)
            4'b0001: w_price = C_PRICE0;
            4'b0010: w_price = C_PRICE1;
            4'b0100: w_price = C_PRICE2;
            4'b1000: w_price = C_PRICE3;
            default: w_price = 5'd0;
        endcase
    end

    assign w_sel_valid = is_onehot4(P);
    assign w_afford    = (w_price <= {1'b0, credit_q});

    vend_change_gen u_change_gen (
        .credit_i (credit_q),
        .coin_o   (w_chg_coin),
        .remain_o (w_chg_remain)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            credit_q <= 4'd0;
            out_q    <= 4'b0000;
            vf_q     <= 3'b000;
            deny_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            // VF and deny are single-cycle pulses unless re-asserted below.
            vf_q   <= 3'b000;
            deny_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_CREDIT: begin
                    // A coin event (credited or echoed) masks P and cancel.
                    if (w_coin_valid) begin
                        if (w_coin_fits) begin
                            credit_q <= w_sum[3:0];
                            state_q  <= ST_CREDIT;
                        end else begin
                            vf_q <= D;
                        end
                    end else if (D == 3'b000) begin
                        if (w_sel_valid) begin
                            if (w_afford) begin
                                credit_q <= credit_q - w_price[3:0];
                                out_q    <= P;
                                cnt_q    <= C_CNT_LD;
                                state_q  <= ST_DISPENSE;
                            end else begin
                                deny_q <= 1'b1;
                            end
                        end else if ((P == 4'b0000) && cancel &&
                                     (state_q == ST_CREDIT)) begin
                            state_q <= ST_CHANGE;
                        end
                    end
                end
                ST_DISPENSE: begin
                    // Counter was loaded with DISP_CYCLES-1 on entry, so the
                    // strobe spans exactly DISP_CYCLES cycles.
                    if (cnt_q == '0) begin
                        out_q   <= 4'b0000;
                        state_q <= (credit_q != 4'd0) ? ST_CHANGE : ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q - C_CNT_1;
                    end
                end
                ST_CHANGE: begin
                    vf_q     <= w_chg_coin;
                    credit_q <= w_chg_remain;
                    if (w_chg_remain == 4'd0) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign OUT    = out_q;
    assign VF     = vf_q;
    assign credit = credit_q;
    assign deny   = deny_q;
    assign busy   = (state_q == ST_DISPENSE) || (state_q == ST_CHANGE);

endmodule
`default_nettype wire

// File: doc/vend_sequencer.md
VEND_SEQUENCER -- requirements
Module: vend_sequencer

Interface
REQ-001 SHALL have parameter PRICE0, default 3: price of product 0, in credit units.
REQ-002 SHALL have parameter PRICE1, default 5: price of product 1.
REQ-003 SHALL have parameter PRICE2, default 7: price of product 2.
REQ-004 SHALL have parameter PRICE3, default 10: price of product 3.
REQ-005 SHALL have parameter DISP_CYCLES, default 4: number of cycles the dispense strobe is held.
REQ-006 SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-007 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port P, input, 4 bits: product select, one-hot, level-sampled.
REQ-009 SHALL have port D, input, 3 bits: coin inserted, one-hot, one cycle per coin; D[0]=1, D[1]=2, D[2]=5 units.
REQ-010 SHALL have port cancel, input, 1 bit: request refund of the current credit.
REQ-011 SHALL have port OUT, output, 4 bits: one-hot dispense strobe for the selected product.
REQ-012 SHALL have port VF, output, 3 bits: one-hot coin-return pulse, same encoding as D.
REQ-013 SHALL have port credit, output, 4 bits: current credit, 0..15.
REQ-014 SHALL have port deny, output, 1 bit: one-cycle pulse when a selection has insufficient credit.
REQ-015 SHALL have port busy, output, 1 bit: high in the DISPENSE and CHANGE states.

Function
REQ-016 SHALL implement the states IDLE (credit=0), CREDIT (credit>0), DISPENSE and CHANGE.
REQ-017 In IDLE or CREDIT, a one-hot D SHALL add its coin value to credit at that edge and move to CREDIT.
REQ-018 A non-one-hot D that is not zero SHALL be ignored.
REQ-019 A coin that would push credit above 15 SHALL NOT be added; its D bit SHALL appear on VF for exactly the next cycle.
REQ-020 In IDLE or CREDIT with D=0, a one-hot P whose price is <= credit SHALL subtract the price, latch P, enter DISPENSE, and drive OUT=latched P starting the next cycle.
REQ-021 A one-hot P whose price is > credit SHALL pulse deny for one cycle and leave credit and state unchanged; non-one-hot P SHALL be ignored.
REQ-022 A valid coin and P in the same cycle: the coin SHALL be processed and P ignored (P must still be present next cycle).
REQ-023 When cancel is high in CREDIT with D=0 and P=0, the block SHALL enter CHANGE; in IDLE, cancel SHALL be ignored.
REQ-024 A valid coin and cancel in the same cycle: the coin SHALL be processed and cancel ignored.
REQ-025 In DISPENSE, OUT SHALL be held for exactly DISP_CYCLES cycles (internal counter), then go to 0.
REQ-026 At the end of DISPENSE, the block SHALL enter CHANGE if credit>0, otherwise IDLE.
REQ-027 In CHANGE, each cycle SHALL emit one VF pulse for the largest coin <= credit (5, then 2, then 1) and subtract that coin from credit.
REQ-028 CHANGE SHALL go to IDLE on the edge where credit reaches 0.
REQ-029 While busy, D, P and cancel SHALL be ignored: coins are not credited and not echoed.
REQ-030 OUT and VF SHALL be registered outputs and never multi-hot; deny SHALL be registered.

Reset
REQ-031 While reset is high at an edge: state=IDLE, credit=0, OUT=0, VF=0, deny=0, busy=0, and the dispense counter is cleared.
REQ-032 Reset SHALL take priority over all inputs, including mid-DISPENSE and mid-CHANGE; the dispense is aborted and credit is lost.

Structure
REQ-033 A shared package vend_pkg SHALL hold the state enum, the coin-value constants (1, 2, 5), default prices, and MAX_CREDIT=15.
REQ-034 Greedy change selection SHALL be one sub-module, vend_change_gen: input credit, outputs a one-hot coin and the remaining credit.

Verification
REQ-035 Scenario: reset; D=001 x3; P=0001 -> credit=3, then credit=0, OUT=0001 for 4 cycles, VF never set, return to IDLE.
REQ-036 Scenario: coins 5,5,2,1 (credit 13); P=0010 -> OUT=0010 for 4 cycles, then VF=100, 010, 001 on consecutive cycles, credit=0, IDLE.
REQ-037 Scenario: credit 2; P=0100 -> deny for 1 cycle, OUT=0, credit stays 2; then cancel -> VF=010 for one cycle, then IDLE.
REQ-038 Scenario: credit 14; D=100 -> credit stays 14, VF=100 for one cycle; then D=001 -> credit=15.
REQ-039 Scenario: credit 2, D=001 and P=0001 in the same cycle -> credit=3, no OUT; P held one more cycle -> dispense starts.
REQ-040 Scenario: reset asserted on the 2nd DISPENSE cycle -> next cycle OUT=0, credit=0, busy=0, no VF.
